alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one combinational ALU between two requesters, alternating grants under contention.
// Latency : accept cycle T, ALU evaluated in T+1, registered result offered from T+2 (3 cycles minimum per op).
// Backpressure: result held in RESP until rsp_ready; no new request is accepted while an op is in flight.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqX_valid/_a/_b/_op/_ready    requester X (X = 0,1) operation handshake; ready is combinational
//   alu_a, alu_b, alu_op           operands/opcode to the shared ALU (zero outside EXEC)
//   alu_result                     combinational ALU result, captured at the end of EXEC
//   rsp_data, rsp0_valid/rsp1_valid, rsp_ready   registered result and its owner
//   busy                           high whenever an operation is in flight
module alu_share_arbiter #(
    parameter int N   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           req1_ready,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [N-1:0]   alu_result,
    output logic [N-1:0]   rsp_data,
    output logic           rsp0_valid,
    output logic           rsp1_valid,
    input  logic           rsp_ready,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;        // requester that wins when both are valid
    logic           grant_id;
    logic           accept;
    logic [N-1:0]   lat_a, lat_b;
    logic [OPW-1:0] lat_op;
    logic           lat_id;
    logic [N-1:0]   rsp_data_q;

    // A lone requester wins regardless of the pointer.
    assign grant_id = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Ready is combinational, so it is masked while reset is held
                // to keep every output quiet during reset.
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                alu_a   = lat_a;
                alu_b   = lat_b;
                alu_op  = lat_op;
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = ~lat_id;
                rsp1_valid = lat_id;
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~lat_id;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_id     <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            // Operands are captured at acceptance so later requester changes
            // cannot disturb the in-flight operation.
            if (accept) begin
                lat_a  <= grant_id ? req1_a  : req0_a;
                lat_b  <= grant_id ? req1_b  : req0_b;
                lat_op <= grant_id ? req1_op : req0_op;
                lat_id <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_result;
            end
        end
    end

    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        req0_ready, req1_ready;
    logic [31:0] alu_a, alu_b, alu_result, rsp_data;
    logic [3:0]  alu_op;
    logic        rsp0_valid, rsp1_valid, busy;
    logic        rsp_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    alu_share_arbiter #(.N(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_data(rsp_data), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: opcode 5 is NOT.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic        id;
        logic [31:0] a, b, res;
        logic [3:0]  op;
        int          acc;
    } txn_t;

    txn_t sb[$];
    txn_t t;
    logic exp_ptr = 1'b0;
    logic gid, acc, e_r0, e_r1, in_exec, in_resp;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_ptr = 1'b0;
            chk1("rst_ready0", req0_ready, 1'b0);
            chk1("rst_ready1", req1_ready, 1'b0);
            chk1("rst_rsp0", rsp0_valid, 1'b0);
            chk1("rst_rsp1", rsp1_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chkw("rst_alu_a", alu_a, 32'h0);
            chkw("rst_rsp_data", rsp_data, 32'h0);
        end else begin
            acc = 1'b0; gid = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
            if (sb.size() == 0 && (req0_valid || req1_valid)) begin
                acc  = 1'b1;
                gid  = (req0_valid && req1_valid) ? exp_ptr : (req1_valid ? 1'b1 : 1'b0);
                e_r0 = (gid == 1'b0);
                e_r1 = (gid == 1'b1);
            end
            chk1("req0_ready", req0_ready, e_r0);
            chk1("req1_ready", req1_ready, e_r1);
            in_exec = (sb.size() != 0) && (cyc == sb[0].acc + 1);
            in_resp = (sb.size() != 0) && (cyc >= sb[0].acc + 2);
            chk1("busy", busy, in_exec || in_resp);
            chkw("alu_a", alu_a, in_exec ? sb[0].a : 32'h0);
            chkw("alu_b", alu_b, in_exec ? sb[0].b : 32'h0);
            chkw("alu_op", {28'h0, alu_op}, in_exec ? {28'h0, sb[0].op} : 32'h0);
            chk1("rsp0_valid", rsp0_valid, in_resp && (sb[0].id == 1'b0));
            chk1("rsp1_valid", rsp1_valid, in_resp && (sb[0].id == 1'b1));
            if (in_resp) begin
                chkw("rsp_data", rsp_data, sb[0].res);
                if (rsp_ready) begin
                    exp_ptr = ~sb[0].id;
                    void'(sb.pop_front());
                end
            end
            if (acc) begin
                t.id  = gid;
                t.a   = gid ? req1_a : req0_a;
                t.b   = gid ? req1_b : req0_b;
                t.op  = gid ? req1_op : req0_op;
                t.res = alu_ref(t.a, t.b, t.op);
                t.acc = cyc;
                sb.push_back(t);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input logic id, output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? rsp1_valid : rsp0_valid) begin
                n = i + 1;
                break;
            end
        end
    endtask

    task automatic go_idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (n) step();
    endtask

    int n;
    logic [31:0] held;
    logic grants[$];

    initial begin
        // Reset state
        repeat (3) step();
        #2 rst_n = 1'b1;

        // Single op: NOT of 0xFF from requester 0
        step();
        req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0; req0_op = 4'd5; rsp_ready = 1'b1;
        step();
        req0_valid = 1'b0; req0_a = 32'h0;
        @(negedge clk);
        chkw("single_alu_a", alu_a, 32'h0000_00FF);
        wait_rsp(1'b0, n);
        chkw("single_latency", n, 32'd1);
        chkw("single_result", rsp_data, 32'hFFFF_FF00);
        go_idle(3);

        // Operand change after acceptance
        req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h20; req0_op = 4'd0;
        step();
        req0_valid = 1'b0; req0_a = 32'h1234;
        wait_rsp(1'b0, n);
        chk1("opchg_seen", n > 0, 1'b1);
        chkw("opchg_result", rsp_data, 32'h30);
        go_idle(3);

        // Reset asserted mid-EXEC
        req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'h7; req1_op = 4'd3;
        step();
        req1_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chkw("midrst_alu_a", alu_a, 32'h0);
        chkw("midrst_alu_b", alu_b, 32'h0);
        chk1("midrst_rsp", rsp0_valid | rsp1_valid, 1'b0);
        chkw("midrst_data", rsp_data, 32'h0);
        repeat (2) step();
        #2 rst_n = 1'b1;

        // Contention from reset: grants alternate starting with requester 0
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_a = 32'h3; req0_b = 32'h1; req0_op = 4'd1;
        req1_a = 32'h9; req1_b = 32'h2; req1_op = 4'd6;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) grants.push_back(req1_ready);
        end
        chkw("contend_count", grants.size(), 32'd4);
        for (int i = 0; i < grants.size(); i++) chk1("contend_grant", grants[i], i[0]);
        go_idle(4);

        // Stall in RESP, then solo priority with pointer at 1
        req0_valid = 1'b1; req0_a = 32'hA5A5_0000; req0_b = 32'h0000_5A5A; req0_op = 4'd4; rsp_ready = 1'b0;
        wait_rsp(1'b0, n);
        chk1("stall_seen", n > 0, 1'b1);
        held = rsp_data;
        chkw("stall_value", held, 32'hA5A5_5A5A);
        for (int k = 0; k < 5; k++) begin
            chk1("stall_rsp0", rsp0_valid, 1'b1);
            chkw("stall_data", rsp_data, held);
            chk1("stall_ready", req0_ready | req1_ready, 1'b0);
            chk1("stall_busy", busy, 1'b1);
            step();
            @(negedge clk);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("release_busy", busy, 1'b0);
        chk1("solo_req0_ready", req0_ready, 1'b1);
        go_idle(4);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15));
            req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        go_idle(8);
        chkw("drain_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
